// File: rtl/p_wff_seq_ctrl.sv
// Sweep sequencer for the p_wff pipeline: runs node-address sweeps until no flow moves
// or the iteration limit is hit, then sums the negative sink excess words into max_flow.
module p_wff_seq_ctrl #(
  parameter  int X          = 12,
  parameter  int Y          = 12,
  parameter  int Z          = 7,
  parameter  int CNT_LIMIT  = 20,
  parameter  int EX_WIDTH   = 14,
  parameter  int MF_WIDTH   = 22,
  localparam int ADDR_WIDTH = $clog2(X*Y*Z),
  localparam int XY_WIDTH   = $clog2(X*Y) + 1,
  localparam int LAYER_W    = $clog2(Z) + 1,
  localparam int ITER_W     = $clog2(CNT_LIMIT) + 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [MF_WIDTH-1:0]   init_flow,
  output logic                  node_valid,
  input  logic                  node_ready,
  output logic [ADDR_WIDTH-1:0] node_addr,
  output logic [LAYER_W-1:0]    node_layer,
  input  logic                  push_seen,
  input  logic                  pipe_empty,
  output logic                  sink_rd_en,
  output logic [XY_WIDTH-1:0]   sink_rd_addr,
  input  logic [EX_WIDTH-1:0]   sink_rd_data,
  output logic [ITER_W-1:0]     iter_cnt,
  output logic                  busy,
  output logic [MF_WIDTH-1:0]   max_flow,
  output logic                  finish,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SWEEP = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_READ  = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(X*Y*Z - 1);
  localparam logic [XY_WIDTH-1:0]   LAST_XY    = XY_WIDTH'(X*Y - 1);
  localparam logic [ITER_W-1:0]     ITER_LIMIT = ITER_W'(CNT_LIMIT);

  state_t                r_state;
  logic                  r_node_valid;
  logic [ADDR_WIDTH-1:0] r_node_addr;
  logic [XY_WIDTH-1:0]   r_xy_cnt;
  logic [LAYER_W-1:0]    r_node_layer;
  logic                  r_changed;
  logic                  r_sink_rd_en;
  logic [XY_WIDTH-1:0]   r_sink_rd_addr;
  logic                  r_rd_pend;
  logic [ITER_W-1:0]     r_iter_cnt;
  logic                  r_busy;
  logic [MF_WIDTH-1:0]   r_acc;
  logic [MF_WIDTH-1:0]   r_max_flow;
  logic                  r_finish;

  logic                  w_hs;
  logic [MF_WIDTH-1:0]   w_ext;
  logic [MF_WIDTH-1:0]   w_acc_next;
  logic [ITER_W-1:0]     w_iter_inc;

  // Node handshake: an address transfers on a cycle where node_valid and node_ready are
  // both high; node_valid never drops and node_addr never changes until that transfer.
  assign w_hs       = r_node_valid & node_ready;
  assign w_ext      = MF_WIDTH'($signed(sink_rd_data));
  assign w_acc_next = (r_rd_pend && sink_rd_data[EX_WIDTH-1]) ? r_acc + w_ext : r_acc;
  assign w_iter_inc = r_iter_cnt + ITER_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_node_valid   <= 1'b0;
      r_node_addr    <= '0;
      r_xy_cnt       <= '0;
      r_node_layer   <= '0;
      r_changed      <= 1'b0;
      r_sink_rd_en   <= 1'b0;
      r_sink_rd_addr <= '0;
      r_rd_pend      <= 1'b0;
      r_iter_cnt     <= '0;
      r_busy         <= 1'b0;
      r_acc          <= '0;
      r_max_flow     <= '0;
      r_finish       <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe, so the strobe is delayed to qualify it.
      r_rd_pend <= r_sink_rd_en;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_SWEEP;
            r_iter_cnt   <= '0;
            r_node_addr  <= '0;
            r_xy_cnt     <= '0;
            r_node_layer <= '0;
            r_acc        <= init_flow;
            r_changed    <= 1'b0;
            r_node_valid <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (push_seen) r_changed <= 1'b1;
          if (w_hs) begin
            if (r_node_addr == LAST_ADDR) begin
              r_node_valid <= 1'b0;
              r_state      <= S_WAIT;
            end else begin
              r_node_addr <= r_node_addr + ADDR_WIDTH'(1);
              // Layer tracked by a wrapping in-layer counter instead of dividing the address.
              if (r_xy_cnt == LAST_XY) begin
                r_xy_cnt     <= '0;
                r_node_layer <= r_node_layer + LAYER_W'(1);
              end else begin
                r_xy_cnt <= r_xy_cnt + XY_WIDTH'(1);
              end
            end
          end
        end
        S_WAIT: begin
          if (push_seen) r_changed <= 1'b1;
          if (pipe_empty) r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_iter_cnt <= w_iter_inc;
          if (w_iter_inc == ITER_LIMIT || !r_changed) begin
            r_state        <= S_READ;
            r_sink_rd_en   <= 1'b1;
            r_sink_rd_addr <= '0;
          end else begin
            r_state      <= S_SWEEP;
            r_node_valid <= 1'b1;
            r_node_addr  <= '0;
            r_xy_cnt     <= '0;
            r_node_layer <= '0;
            r_changed    <= 1'b0;
          end
        end
        S_READ: begin
          r_acc <= w_acc_next;
          if (r_sink_rd_addr == LAST_XY) begin
            r_sink_rd_en <= 1'b0;
            r_state      <= S_FLUSH;
          end else begin
            r_sink_rd_addr <= r_sink_rd_addr + XY_WIDTH'(1);
          end
        end
        S_FLUSH: begin
          r_acc      <= w_acc_next;
          r_max_flow <= w_acc_next;
          r_finish   <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (!start) begin
            r_finish <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign node_valid   = r_node_valid;
  assign node_addr    = r_node_addr;
  assign node_layer   = r_node_layer;
  assign sink_rd_en   = r_sink_rd_en;
  assign sink_rd_addr = r_sink_rd_addr;
  assign iter_cnt     = r_iter_cnt;
  assign busy         = r_busy;
  assign max_flow     = r_max_flow;
  assign finish       = r_finish;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_p_wff_seq_ctrl.sv
// Bench for p_wff_seq_ctrl on a 2x2x2 grid, 3 iterations max, 8-bit accumulator.
`timescale 1ns/1ps
module tb_p_wff_seq_ctrl;
  localparam int X = 2, Y = 2, Z = 2, CNT_LIMIT = 3, EX_WIDTH = 14, MF_WIDTH = 8;
  localparam int N   = X*Y*Z;
  localparam int XY  = X*Y;
  localparam int AW  = $clog2(N);
  localparam int XYW = $clog2(XY) + 1;
  localparam int LW  = $clog2(Z) + 1;
  localparam int IW  = $clog2(CNT_LIMIT) + 1;

  logic                clk = 1'b0;
  logic                n_rst;
  logic                start;
  logic [MF_WIDTH-1:0] init_flow;
  logic                node_valid;
  logic                node_ready;
  logic [AW-1:0]       node_addr;
  logic [LW-1:0]       node_layer;
  logic                push_seen;
  logic                pipe_empty;
  logic                sink_rd_en;
  logic [XYW-1:0]      sink_rd_addr;
  logic [EX_WIDTH-1:0] sink_rd_data;
  logic [IW-1:0]       iter_cnt;
  logic                busy;
  logic [MF_WIDTH-1:0] max_flow;
  logic                finish;
  logic [2:0]          dbg_state;

  p_wff_seq_ctrl #(
    .X(X), .Y(Y), .Z(Z), .CNT_LIMIT(CNT_LIMIT), .EX_WIDTH(EX_WIDTH), .MF_WIDTH(MF_WIDTH)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .init_flow(init_flow),
    .node_valid(node_valid), .node_ready(node_ready), .node_addr(node_addr),
    .node_layer(node_layer), .push_seen(push_seen), .pipe_empty(pipe_empty),
    .sink_rd_en(sink_rd_en), .sink_rd_addr(sink_rd_addr), .sink_rd_data(sink_rd_data),
    .iter_cnt(iter_cnt), .busy(busy), .max_flow(max_flow), .finish(finish),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // push[k]: 0 = no push in sweep k, 1 = push during the sweep, 2 = push in the drain wait
  typedef struct {
    logic [MF_WIDTH-1:0] init;
    int                  push [CNT_LIMIT];
    int                  ready_mode;
    int                  wait_cyc;
    int                  hold;
    int                  words [XY];
    logic [MF_WIDTH-1:0] exp_mf;
    int                  exp_iter;
  } vec_t;

  vec_t                tbl [7];
  logic [LW+AW-1:0]    exp_q [$];
  int                  total = 0;
  int                  bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [MF_WIDTH-1:0] init,
                         input int p0, input int p1, input int p2, input int rm,
                         input int wc, input int hold, input int w0, input int w1,
                         input int w2, input int w3, input logic [MF_WIDTH-1:0] emf,
                         input int eit);
    tbl[i].init = init;
    tbl[i].push[0] = p0; tbl[i].push[1] = p1; tbl[i].push[2] = p2;
    tbl[i].ready_mode = rm;
    tbl[i].wait_cyc = wc;
    tbl[i].hold = hold;
    tbl[i].words[0] = w0; tbl[i].words[1] = w1; tbl[i].words[2] = w2; tbl[i].words[3] = w3;
    tbl[i].exp_mf = emf;
    tbl[i].exp_iter = eit;
  endtask

  // Reference: sweeps continue while the last sweep pushed, up to the limit; result is
  // the seed plus every negative sink word, reduced modulo 2^MF_WIDTH.
  function automatic void model(input vec_t v, output logic [MF_WIDTH-1:0] mf,
                                output int it);
    longint s;
    longint m;
    m  = longint'(1) << MF_WIDTH;
    s  = longint'(v.init);
    it = 0;
    for (int k = 0; k < CNT_LIMIT; k++) begin
      it++;
      if (v.push[k] == 0) break;
    end
    for (int a = 0; a < XY; a++)
      if (v.words[a] < 0) s += longint'(v.words[a]);
    s = s % m;
    if (s < 0) s += m;
    mf = MF_WIDTH'(s);
  endfunction

  function automatic logic ready_val(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cyc[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc, phase, sweep_idx, hs_cnt, wcnt, rd_cnt, rd_idx, pick, pmode, exp_lat;
    bit pushed, rd_pend, done;
    exp_q.delete();
    for (int s = 0; s < v.exp_iter; s++)
      for (int a = 0; a < N; a++) exp_q.push_back({LW'(a / XY), AW'(a)});
    @(negedge clk);
    start = 1'b1; init_flow = v.init; node_ready = 1'b0; push_seen = 1'b0; pipe_empty = 1'b0;
    cyc = 0; phase = 2; sweep_idx = -1; hs_cnt = 0; wcnt = 0; rd_cnt = 0; rd_idx = 0;
    pick = 0; pushed = 0; rd_pend = 0; done = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start        = 1'($urandom_range(0, 1));
      init_flow    = MF_WIDTH'($urandom);
      push_seen    = 1'b0;
      pipe_empty   = 1'($urandom_range(0, 1));
      node_ready   = 1'($urandom_range(0, 1));
      sink_rd_data = rd_pend ? EX_WIDTH'(v.words[rd_idx]) : EX_WIDTH'($urandom);
      rd_pend      = 0;
      if (finish) begin
        done = 1;
      end else begin
        check("busy_run", busy, 1);
        if (sink_rd_en) begin
          check("rd_addr", sink_rd_addr, rd_cnt);
          rd_pend = 1;
          rd_idx  = (rd_cnt < XY) ? rd_cnt : 0;
          rd_cnt++;
        end
        if (node_valid) begin
          if (phase == 2) begin
            phase = 0; sweep_idx++; hs_cnt = 0; pushed = 0; pick = $urandom_range(0, N-1);
          end
          pmode = (sweep_idx >= 0 && sweep_idx < CNT_LIMIT) ? v.push[sweep_idx] : 0;
          node_ready = ready_val(v.ready_mode, cyc);
          if (pmode == 1 && !pushed && hs_cnt >= pick) begin
            push_seen = 1'b1;
            pushed    = 1;
          end
          if (exp_q.size() == 0) begin
            check("extra_valid", {node_layer, node_addr}, '1);
          end else begin
            check("node_addr_layer", {node_layer, node_addr}, exp_q[0]);
            if (node_ready) void'(exp_q.pop_front());
          end
          if (node_ready) begin
            hs_cnt++;
            if (hs_cnt == N) begin
              phase = 1;
              wcnt  = 0;
            end
          end
        end else if (phase == 1) begin
          pmode = (sweep_idx >= 0 && sweep_idx < CNT_LIMIT) ? v.push[sweep_idx] : 0;
          wcnt++;
          pipe_empty = (wcnt >= v.wait_cyc);
          if (pmode == 2 && wcnt == v.wait_cyc) push_seen = 1'b1;
          if (pipe_empty) phase = 2;
        end else if (phase == 2) begin
          push_seen = 1'($urandom_range(0, 1));
        end
      end
    end
    check("finish_seen", done, 1);
    check("busy_done", busy, 0);
    check("valid_done", node_valid, 0);
    check("rd_en_done", sink_rd_en, 0);
    check("max_flow", max_flow, v.exp_mf);
    check("iter_cnt", iter_cnt, v.exp_iter);
    check("addr_left", exp_q.size(), 0);
    check("rd_count", rd_cnt, XY);
    if (v.ready_mode == 0) begin
      exp_lat = v.exp_iter * (N + v.wait_cyc + 1) + XY + 2;
      check("latency", cyc, exp_lat);
    end
    start = (v.hold > 0);
    push_seen = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("finish_hold", finish, 1);
      check("max_flow_hold", max_flow, v.exp_mf);
      if (h == v.hold - 1) start = 1'b0;
    end
    @(negedge clk);
    check("finish_idle", finish, 0);
    check("busy_idle", busy, 0);
    check("max_flow_idle", max_flow, v.exp_mf);
    check("iter_idle", iter_cnt, v.exp_iter);
    @(negedge clk);
    check("valid_idle", node_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, node_valid, 0);
    check({tag, "_addr"}, node_addr, 0);
    check({tag, "_layer"}, node_layer, 0);
    check({tag, "_rd_en"}, sink_rd_en, 0);
    check({tag, "_rd_addr"}, sink_rd_addr, 0);
    check({tag, "_iter"}, iter_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_max_flow"}, max_flow, 0);
    check({tag, "_finish"}, finish, 0);
  endtask

  task automatic reset_mid_sweep();
    bit hit;
    hit = 0;
    @(negedge clk);
    start = 1'b1; init_flow = 8'h33; push_seen = 1'b0; pipe_empty = 1'b0; node_ready = 1'b1;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      node_ready = 1'b1;
      if (node_valid && node_addr == AW'(5)) hit = 1;
    end
    check("reach_addr5", hit, 1);
    n_rst = 1'b0;
    start = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", node_valid, 0);
    end
  endtask

  initial begin
    vec_t rv;
    n_rst = 1'b1; start = 1'b0; init_flow = '0; node_ready = 1'b0;
    push_seen = 1'b0; pipe_empty = 1'b0; sink_rd_data = '0;
    #2 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    //       i  init   p0 p1 p2 rm wc hold  w0     w1    w2  w3   exp_mf  iter
    set_vec(0, 8'd0,   1, 1, 1, 0, 1,  2,     0,     0,  0,  0,   8'd0,   3);
    set_vec(1, 8'd100, 1, 1, 1, 0, 1,  0,    -5,     7, -1,  0,   8'd94,  3);
    set_vec(2, 8'd100, 0, 0, 0, 0, 1,  1,    -5,     7, -1,  0,   8'd94,  1);
    set_vec(3, 8'd2,   1, 0, 0, 1, 10, 3,    -5,     0,  0,  0,   8'hFD,  2);
    set_vec(4, 8'd10,  2, 1, 0, 2, 3,  1,    -1,    -1, -1, -1,   8'd6,   3);
    set_vec(5, 8'd240, 1, 2, 0, 0, 2,  0,   -20,     5, -3,  3,   8'd217, 3);
    set_vec(6, 8'd5,   2, 0, 1, 1, 1,  2, -8192,  8191,  0, -1,   8'd4,   2);
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    reset_mid_sweep();

    for (int r = 0; r < 25; r++) begin
      rv.init = MF_WIDTH'($urandom);
      for (int k = 0; k < CNT_LIMIT; k++) rv.push[k] = $urandom_range(0, 2);
      rv.ready_mode = $urandom_range(0, 2);
      rv.wait_cyc   = $urandom_range(1, 5);
      rv.hold       = $urandom_range(0, 2);
      for (int a = 0; a < XY; a++)
        rv.words[a] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191))
                                                  : -int'($urandom_range(1, 8192));
      model(rv, rv.exp_mf, rv.exp_iter);
      run_vec(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
